// File: rtl/dual_rate_event_counter_if.sv
// Strobe/event inputs and status outputs of the
// dual-rate event counter, bundled for port hookup.
interface dual_rate_event_counter_if #(
  parameter int WIDTH = 8
);
  logic             tick_a;
  logic             tick_b;
  logic             sel;
  logic             clr;
  logic             di;
  logic             dco;
  logic [WIDTH-1:0] count;
  logic             ovf;

  modport master (
    output tick_a, tick_b, sel, clr, di,
    input  dco, count, ovf
  );

  modport slave (
    input  tick_a, tick_b, sel, clr, di,
    output dco, count, ovf
  );
endinterface

// File: rtl/dual_rate_event_counter.sv
// Single-clock event capture and rise counter
// advanced by one of two selectable rate strobes.
module dual_rate_event_counter #(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  dual_rate_event_counter_if.slave   bus
);
  localparam int SW = STAGES - 1;

  logic             sel_q;
  logic [SW-1:0]    sr_q, sr_d;
  logic             dco_q, dco_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             rise;

  // sel is registered, so a rate change lands one clk late
  assign tick = sel_q ? bus.tick_b : bus.tick_a;
  assign rise = bus.di & ~sr_q[0];

  // registered rate select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= 1'b0;
    else        sel_q <= bus.sel;
  end

  // next state: clear beats tick, otherwise hold
  always_comb begin
    sr_d    = sr_q;
    dco_d   = dco_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      sr_d    = '0;
      dco_d   = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (tick) begin
      sr_d[0] = bus.di;
      for (int k = 1; k < SW; k++)
        sr_d[k] = sr_q[k-1];
      dco_d = bus.di | (|sr_q);
      if (rise) begin
        if (count_q != {WIDTH{1'b1}}) begin
          count_d = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
          if (SATURATE == 0) count_d = '0;
        end
      end
    end
  end

  // capture pipeline, count and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      dco_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      dco_q   <= dco_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.dco   = dco_q;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
endmodule
